nios_lcd_strobe: RTL and testbench

Downstream companion to the LCD RS/data PIO registers. An Avalon-MM slave that accepts HD44780 command and data bytes into a small FIFO. It replays each byte on the LCD bus with RS/DB setup, an E pulse of fixed width, hold, and a post-write execution delay, so software never bit-bangs E or busy-waits. It sits between the Nios data master and the LCD pins.

---
 rtl/nios_lcd_strobe_pkg.sv | 42 ++++
 rtl/nios_lcd_strobe_if.sv | 11 +
 rtl/nios_lcd_strobe_fifo.sv | 44 ++++
 rtl/nios_lcd_strobe.sv | 154 +++++++++++++++
 tb/tb_nios_lcd_strobe.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nios_lcd_strobe_pkg.sv
// Shared definitions for the HD44780 strobe engine: FSM encoding, register map,
// status bit positions, long-delay opcodes and the power-up command ROM.
package nios_lcd_pkg;

  typedef logic [2:0] lcd_state_t;

  localparam lcd_state_t ST_IDLE  = 3'd0;
  localparam lcd_state_t ST_SETUP = 3'd1;
  localparam lcd_state_t ST_PULSE = 3'd2;
  localparam lcd_state_t ST_HOLD  = 3'd3;
  localparam lcd_state_t ST_WAIT  = 3'd4;
  localparam lcd_state_t ST_INIT  = 3'd5;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CMD    = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_LVL_LSB = 8;

  localparam logic [7:0] OP_CLEAR = 8'h01;
  localparam logic [7:0] OP_HOME  = 8'h02;

  localparam int INIT_LEN    = 4;
  localparam int POWERUP_CYC = 750000;

  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nios_lcd_strobe_if.sv
// Avalon-MM slave bus bundle between the Nios data master and the LCD strobe engine.
interface nios_lcd_strobe_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/nios_lcd_strobe_fifo.sv
// Synchronous FIFO holding {rs, byte} entries; a push while full is dropped.
module nios_lcd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q;
  logic             do_push, do_pop;

  // Pointers carry one wrap bit so full and empty differ only in that bit.
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign level_o = wr_q - rd_q;
  assign head_o  = mem_q[rd_q[AW-1:0]];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/nios_lcd_strobe.sv
// HD44780 write strobe engine: queues bytes from Avalon writes and replays them with
// setup/E-pulse/hold/exec timing. Define LCD_INIT_SEQ_EN for the built-in power-up sequence.
module nios_lcd_strobe
  import nios_lcd_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int SETUP_CYC  = 4,
  parameter int PULSE_CYC  = 25,
  parameter int HOLD_CYC   = 2,
  parameter int EXEC_CYC   = 2000,
  parameter int CLR_CYC    = 82000
) (
  input  logic               clk,
  input  logic               reset,
  nios_lcd_strobe_if.slave   avs,
  output logic               lcd_rs,
  output logic               lcd_e,
  output logic [7:0]         lcd_db
);
  localparam int MAX_BASE = max_int(max_int(max_int(FIFO_DEPTH, SETUP_CYC),
                                            max_int(PULSE_CYC, HOLD_CYC)),
                                    max_int(EXEC_CYC, CLR_CYC));
`ifdef LCD_INIT_SEQ_EN
  localparam int MAX_CYC = max_int(MAX_BASE, POWERUP_CYC);
`else
  localparam int MAX_CYC = MAX_BASE;
`endif
  localparam int CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(CLR_CYC - 1);

  lcd_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rs_q, rs_d, e_q, ovf_q;
  logic [7:0]       db_q, db_d;
  logic             wr_en, push_req, ovf_clr, pop, full, empty, busy, cnt_zero;
  logic [8:0]       head;
  logic [LVL_W-1:0] level;
  logic             unused_wdata;
`ifdef LCD_INIT_SEQ_EN
  localparam logic [CNT_W-1:0] POWERUP_LD = CNT_W'(POWERUP_CYC - 1);
  logic [2:0]       idx_q, idx_d;
`endif

  function automatic logic long_delay(input logic rs, input logic [7:0] db);
    return !rs && (db == OP_CLEAR || db == OP_HOME);
  endfunction

  assign wr_en        = avs.chipselect & ~avs.write_n;
  assign push_req     = wr_en & ((avs.address == ADDR_DATA) | (avs.address == ADDR_CMD));
  assign ovf_clr      = wr_en & (avs.address == ADDR_STATUS);
  assign unused_wdata = ^avs.writedata[31:8];

  nios_lcd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(9)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_req),
    .data_i  ({avs.address == ADDR_DATA, avs.writedata[7:0]}),
    .pop_i   (pop),
    .head_o  (head),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  assign busy          = (state_q != ST_IDLE) | ~empty;
  assign cnt_zero      = (cnt_q == '0);
  assign avs.readdata  = (avs.address == ADDR_STATUS) ?
                         {16'b0, 8'(level), 5'b0, ovf_q, full, busy} : 32'b0;
  assign lcd_rs        = rs_q;
  assign lcd_db        = db_q;
  assign lcd_e         = e_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_zero ? cnt_q : cnt_q - 1'b1;
    rs_d    = rs_q;
    db_d    = db_q;
    pop     = 1'b0;
`ifdef LCD_INIT_SEQ_EN
    idx_d   = idx_q;
`endif
    case (state_q)
      ST_IDLE: if (!empty) begin
        pop     = 1'b1;
        rs_d    = head[8];
        db_d    = head[7:0];
        cnt_d   = SETUP_LD;
        state_d = ST_SETUP;
      end
      ST_SETUP: if (cnt_zero) begin
        cnt_d   = PULSE_LD;
        state_d = ST_PULSE;
      end
      ST_PULSE: if (cnt_zero) begin
        cnt_d   = HOLD_LD;
        state_d = ST_HOLD;
      end
      ST_HOLD: if (cnt_zero) begin
        cnt_d   = long_delay(rs_q, db_q) ? CLR_LD : EXEC_LD;
        state_d = ST_WAIT;
      end
`ifdef LCD_INIT_SEQ_EN
      ST_WAIT: if (cnt_zero) state_d = (idx_q < 3'(INIT_LEN)) ? ST_INIT : ST_IDLE;
      // Power-up wait ends with cnt at 0; each later visit launches the next ROM command.
      ST_INIT: if (cnt_zero) begin
        rs_d    = 1'b0;
        db_d    = init_rom(idx_q[1:0]);
        idx_d   = idx_q + 1'b1;
        cnt_d   = SETUP_LD;
        state_d = ST_SETUP;
      end
`else
      ST_WAIT: if (cnt_zero) state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef LCD_INIT_SEQ_EN
      state_q <= ST_INIT;
      cnt_q   <= POWERUP_LD;
      idx_q   <= '0;
`else
      state_q <= ST_IDLE;
      cnt_q   <= '0;
`endif
      rs_q    <= 1'b0;
      db_q    <= 8'h00;
      e_q     <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      db_q    <= db_d;
      // E registered from next state so it is high for exactly the PULSE cycles.
      e_q     <= (state_d == ST_PULSE);
      if (push_req && full) ovf_q <= 1'b1;
      else if (ovf_clr)     ovf_q <= 1'b0;
`ifdef LCD_INIT_SEQ_EN
      idx_q   <= idx_d;
`endif
    end
  end

endmodule

// File: tb/tb_nios_lcd_strobe.sv
// Bench for nios_lcd_strobe: vector table, corner-case sequences and random traffic
// checked every cycle against a timeline model of queued LCD writes.
module tb_nios_lcd_strobe;
  localparam int DEPTH  = 8;
  localparam int SETUP  = 4;
  localparam int PULSE  = 25;
  localparam int HOLD   = 2;
  localparam int EXEC   = 40;
  localparam int CLR    = 150;
  localparam int T_NORM = 1 + SETUP + PULSE + HOLD + EXEC;
  localparam int T_CLR  = 1 + SETUP + PULSE + HOLD + CLR;

  logic       clk = 1'b0;
  logic       reset;
  logic       lcd_rs, lcd_e;
  logic [7:0] lcd_db;

  nios_lcd_strobe_if bus ();

  nios_lcd_strobe #(
    .FIFO_DEPTH(DEPTH), .SETUP_CYC(SETUP), .PULSE_CYC(PULSE),
    .HOLD_CYC(HOLD), .EXEC_CYC(EXEC), .CLR_CYC(CLR)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .avs    (bus),
    .lcd_rs (lcd_rs),
    .lcd_e  (lcd_e),
    .lcd_db (lcd_db)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  // Timeline model: per accepted byte, the edges of push, pop, E rise and return to idle.
  int         m_push[$], m_pop[$], m_rise[$], m_end[$];
  logic [8:0] m_val[$];
  int         m_drop = -1;
  int         m_clr  = -1;

  function automatic void model_reset();
    m_push.delete(); m_pop.delete(); m_rise.delete(); m_end.delete(); m_val.delete();
    m_drop = -1;
    m_clr  = -1;
  endfunction

  function automatic void model_push(input logic rs, input logic [7:0] b, input int p);
    int occ, start, rise, dly;
    occ = 0;
    foreach (m_pop[i]) if (m_pop[i] >= p) occ++;
    if (occ >= DEPTH) begin
      m_drop = p;
      return;
    end
    start = p;
    if (m_end.size() != 0 && m_end[$] > p) start = m_end[$];
    rise = start + 1 + SETUP;
    dly  = (!rs && (b == 8'h01 || b == 8'h02)) ? CLR : EXEC;
    m_push.push_back(p);
    m_pop.push_back(start + 1);
    m_rise.push_back(rise);
    m_end.push_back(rise + PULSE + HOLD + dly);
    m_val.push_back({rs, b});
  endfunction

  function automatic logic [41:0] model_out(input int c, input logic [1:0] addr);
    logic        e, busy, ovf;
    logic [8:0]  rsdb;
    int          lvl;
    logic [31:0] stat;
    e = 1'b0; busy = 1'b0; rsdb = 9'h0; lvl = 0;
    foreach (m_push[i]) begin
      if (m_rise[i] <= c && c < m_rise[i] + PULSE) e = 1'b1;
      if (m_pop[i] <= c) rsdb = m_val[i];
      if (m_push[i] <= c && c < m_end[i]) busy = 1'b1;
      if (m_push[i] <= c && c < m_pop[i]) lvl++;
    end
    ovf  = (m_drop > m_clr);
    stat = {16'b0, 8'(lvl), 5'b0, ovf, (lvl == DEPTH), busy};
    return {e, rsdb, (addr == 2'd2) ? stat : 32'b0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(negedge clk);
    chk("cycle", {22'b0, lcd_e, lcd_rs, lcd_db, bus.readdata},
        {22'b0, model_out(cyc, bus.address)});
  endtask

  task automatic drive(input logic cs, input logic wn, input logic [1:0] a, input logic [31:0] d);
    bus.chipselect = cs;
    bus.write_n    = wn;
    bus.address    = a;
    bus.writedata  = d;
    if (cs && !wn && !reset) begin
      case (a)
        2'd0:    model_push(1'b1, d[7:0], cyc + 1);
        2'd1:    model_push(1'b0, d[7:0], cyc + 1);
        2'd2:    m_clr = cyc + 1;
        default: ;
      endcase
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b1, 2'd2, 32'h0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    drive(1'b1, 1'b0, a, {24'b0, d});
    tick();
    idle();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    idle();
    model_reset();
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic watch(input int n, output int nr, output int r1, output int r2);
    logic pe;
    nr = 0; r1 = -1; r2 = -1;
    pe = lcd_e;
    repeat (n) begin
      tick();
      if (lcd_e && !pe) begin
        nr++;
        if (nr == 1) r1 = cyc;
        else if (nr == 2) r2 = cyc;
      end
      pe = lcd_e;
    end
  endtask

  typedef struct {
    logic [1:0] addr;
    logic [7:0] data;
    logic       exp_rs;
    logic [7:0] exp_db;
    int         exp_busy;   // status busy cycles after the write cycle
  } vec_t;

  vec_t vt[7];

  initial begin
    int         p, rise_at, high, busy_n, nr, r1, r2, k, lim;
    logic [8:0] cap;
    logic       pe;
    logic [1:0] ra;
    logic [31:0] rd;

    vt[0] = '{2'd1, 8'h38, 1'b0, 8'h38, T_NORM - 1};
    vt[1] = '{2'd0, 8'h41, 1'b1, 8'h41, T_NORM - 1};
    vt[2] = '{2'd1, 8'h01, 1'b0, 8'h01, T_CLR - 1};
    vt[3] = '{2'd1, 8'h02, 1'b0, 8'h02, T_CLR - 1};
    vt[4] = '{2'd1, 8'h03, 1'b0, 8'h03, T_NORM - 1};
    vt[5] = '{2'd0, 8'h01, 1'b1, 8'h01, T_NORM - 1};
    vt[6] = '{2'd3, 8'h55, 1'b0, 8'h00, 0};

    do_reset(3);
    chk("rst_e",      64'(lcd_e), 64'(0));
    chk("rst_rs",     64'(lcd_rs), 64'(0));
    chk("rst_db",     64'(lcd_db), 64'(0));
    chk("rst_status", 64'(bus.readdata), 64'(0));

    for (int i = 0; i < 7; i++) begin
      wr(vt[i].addr, vt[i].data);
      p = cyc; rise_at = -1; high = 0; busy_n = 0; cap = 9'h0; pe = lcd_e;
      repeat (vt[i].exp_busy + 8) begin
        tick();
        if (lcd_e && !pe) begin
          rise_at = cyc;
          cap = {lcd_rs, lcd_db};
        end
        if (lcd_e) high++;
        if (bus.readdata[0]) busy_n++;
        pe = lcd_e;
      end
      chk("tbl_busy", 64'(busy_n), 64'(vt[i].exp_busy));
      if (vt[i].exp_busy != 0) begin
        chk("tbl_rsdb",  64'(cap), 64'({vt[i].exp_rs, vt[i].exp_db}));
        chk("tbl_rise",  64'(rise_at - p), 64'(SETUP + 1));
        chk("tbl_width", 64'(high), 64'(PULSE));
      end else begin
        chk("tbl_noE", 64'(high), 64'(0));
      end
    end

    // Back-to-back data bytes
    drive(1'b1, 1'b0, 2'd0, 32'h41); tick();
    drive(1'b1, 1'b0, 2'd0, 32'h42); tick();
    idle(); tick();
    chk("b2b_level1", 64'(bus.readdata[15:8]), 64'(1));
    watch(2 * T_NORM + 10, nr, r1, r2);
    chk("b2b_count", 64'(nr), 64'(2));
    chk("b2b_gap",   64'(r2 - r1), 64'(T_NORM));
    chk("b2b_level0", 64'(bus.readdata[15:8]), 64'(0));

    // Clear display holds off the following byte for the long delay
    drive(1'b1, 1'b0, 2'd1, 32'h01); tick();
    drive(1'b1, 1'b0, 2'd0, 32'h55); tick();
    idle();
    watch(T_CLR + T_NORM + 10, nr, r1, r2);
    chk("clr_count", 64'(nr), 64'(2));
    chk("clr_gap",   64'(r2 - r1), 64'(T_CLR));

    // Overflow: ten writes while busy into an eight-entry queue
    wr(2'd0, 8'h30);
    repeat (3) tick();
    for (int j = 0; j < 10; j++) begin
      drive(1'b1, 1'b0, 2'd0, 32'h60 + 32'(j));
      tick();
    end
    idle(); tick();
    chk("ovf_status", 64'(bus.readdata[15:0]), 64'(16'h0807));
    watch(9 * T_NORM, nr, r1, r2);
    chk("ovf_strobes", 64'(nr), 64'(8));
    chk("ovf_sticky", 64'(bus.readdata[2]), 64'(1));
    wr(2'd2, 8'h00);
    tick();
    chk("ovf_cleared", 64'(bus.readdata[2:0]), 64'(0));

    // Reset in the middle of the E pulse
    wr(2'd1, 8'h0C);
    k = 0;
    while (!lcd_e && k < 20) begin
      tick();
      k++;
    end
    chk("rstp_pulse_seen", 64'(lcd_e), 64'(1));
    repeat (3) tick();
    do_reset(1);
    chk("rstp_e",      64'(lcd_e), 64'(0));
    chk("rstp_status", 64'(bus.readdata), 64'(0));
    watch(200, nr, r1, r2);
    chk("rstp_no_strobe", 64'(nr), 64'(0));

    // Random traffic
    repeat (400) begin
      k = int'($urandom_range(0, 99));
      ra = 2'($urandom_range(0, 3));
      rd = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 2)) : $urandom;
      if (k < 15)      drive(1'b1, 1'b0, ra, rd);
      else if (k < 20) drive(1'b1, 1'b1, ra, rd);
      else             idle();
      tick();
    end
    idle();
    lim = (m_end.size() != 0) ? m_end[$] : cyc;
    k = 0;
    while (cyc < lim + 3 && k < 5000) begin
      tick();
      k++;
    end
    chk("rand_drained", 64'(bus.readdata[0]), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
